// File: rtl/egg_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : egg_display_scan
// Brief    : Four-digit multiplexed seven-segment scanner with frame-boundary
//            shadow transfer. Optional flashing enabled by defining BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module egg_display_scan #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lead,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int c_cntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_cntW-1:0] c_blankLast = c_cntW'(BLANK_CYCLES - 1);
  localparam logic [c_cntW-1:0] c_slotLast  = c_cntW'(PRESCALE - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scanState_t;

  scanState_t        r_state;
  scanState_t        w_nextState;
  logic [c_cntW-1:0] r_cnt;
  logic [c_cntW-1:0] w_nextCnt;
  logic [1:0]        r_idx;
  logic [1:0]        w_nextIdx;
  logic [15:0]       r_shadowDigits;
  logic [3:0]        r_shadowDp;
  logic [15:0]       r_activeDigits;
  logic [3:0]        r_activeDp;
  logic              w_frameEnd;
  logic              w_nextFrameDone;
  logic              w_blinkOff;
  logic              w_lit;
  logic              w_leadBlank;
  logic [3:0]        w_digit;
  logic [6:0]        w_segDecoded;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_idx   <= w_nextIdx;
    end
  end

  // The counter spans the whole slot; BLANK and DRIVE are windows within it.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt + c_cntW'(1);
    w_nextIdx   = r_idx;
    w_frameEnd  = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == c_blankLast) w_nextState = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (r_cnt == c_slotLast) begin
          w_nextCnt   = '0;
          w_nextIdx   = r_idx + 2'd1;
          w_nextState = ST_BLANK;
          w_frameEnd  = (r_idx == 2'd3);
        end
      end
      default: begin
        w_nextState = ST_BLANK;
        w_nextCnt   = '0;
      end
    endcase
  end

  // A load on the frame-end edge bypasses the shadow so it is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadowDigits <= 16'h0;
      r_shadowDp     <= 4'h0;
      r_activeDigits <= 16'h0;
      r_activeDp     <= 4'h0;
    end else begin
      if (load) begin
        r_shadowDigits <= digits_in;
        r_shadowDp     <= dp_in;
      end
      if (w_frameEnd) begin
        r_activeDigits <= load ? digits_in : r_shadowDigits;
        r_activeDp     <= load ? dp_in     : r_shadowDp;
      end
    end
  end

`ifdef BLINK_EN
  localparam int c_bfW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_bfW-1:0] c_bfLast = c_bfW'(BLINK_FRAMES - 1);

  logic [c_bfW-1:0] r_frameCnt;
  logic             r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frameCnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_frameEnd) begin
      if (r_frameCnt == c_bfLast) begin
        r_frameCnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_frameCnt <= r_frameCnt + c_bfW'(1);
      end
    end
  end

  assign w_blinkOff = blink & r_phase;
`else
  localparam int c_unusedBlinkFrames = BLINK_FRAMES;
  logic w_unusedBlink;
  assign w_unusedBlink = blink;
  assign w_blinkOff    = 1'b0;
`endif

  // Outputs are computed from the next scan position so they stay registered
  // yet line up with the state they describe.
  assign w_nextFrameDone = (w_nextState == ST_DRIVE) && (w_nextIdx == 2'd3) &&
                           (w_nextCnt == c_slotLast);
  assign w_lit   = (w_nextState == ST_DRIVE) && !w_blinkOff;
  assign w_digit = r_activeDigits[{w_nextIdx, 2'b00} +: 4];

  always_comb begin
    w_leadBlank = 1'b0;
    case (w_nextIdx)
      2'd3:    w_leadBlank = blank_lead && (r_activeDigits[15:12] == 4'h0);
      2'd2:    w_leadBlank = blank_lead && (r_activeDigits[15:8] == 8'h0);
      2'd1:    w_leadBlank = blank_lead && (r_activeDigits[15:4] == 12'h0);
      default: w_leadBlank = 1'b0;
    endcase
  end

  always_comb begin
    w_segDecoded = 7'b0111111;
    case (w_digit)
      4'd0:    w_segDecoded = 7'b1000000;
      4'd1:    w_segDecoded = 7'b1111001;
      4'd2:    w_segDecoded = 7'b0100100;
      4'd3:    w_segDecoded = 7'b0110000;
      4'd4:    w_segDecoded = 7'b0011001;
      4'd5:    w_segDecoded = 7'b0010010;
      4'd6:    w_segDecoded = 7'b0000010;
      4'd7:    w_segDecoded = 7'b1111000;
      4'd8:    w_segDecoded = 7'b0000000;
      4'd9:    w_segDecoded = 7'b0010000;
      default: w_segDecoded = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= w_lit ? ~(4'b0001 << w_nextIdx) : 4'hF;
      seg        <= (w_lit && !w_leadBlank) ? w_segDecoded : 7'h7F;
      dp         <= w_lit ? ~r_activeDp[w_nextIdx] : 1'b1;
      frame_done <= w_nextFrameDone;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_egg_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_egg_display_scan
// Brief    : Randomized bench for egg_display_scan against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_egg_display_scan;

  localparam int P     = 8;
  localparam int B     = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * P;
  localparam int TOTAL = 2400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lead = 1'b0;
  logic        blink = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  egg_display_scan #(
    .PRESCALE    (P),
    .BLANK_CYCLES(B),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lead(blank_lead),
    .blink     (blink),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t;
  logic [15:0] latestD, shownD;
  logic [3:0]  latestP, shownP;
  logic        prevBlankLead, prevBlink;
  logic [6:0]  segTab [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic modelReset();
    t       = 0;
    latestD = 16'h0;
    latestP = 4'h0;
    shownD  = 16'h0;
    shownP  = 4'h0;
  endtask

  // Expected pins for position t within the scan, from the slot/frame arithmetic.
  task automatic checkOutputs();
    int pos, d, f;
    logic lit, leadZero;
    logic [3:0] one, nib, expAn;
    logic [6:0] expSeg;
    logic expDp, expFd;
    pos = t % P;
    d   = (t / P) % 4;
    f   = t / FRAME;
    lit = (pos >= B);
`ifdef BLINK_EN
    if (prevBlink && (((f / BF) % 2) == 1)) lit = 1'b0;
`endif
    one      = 4'b0001;
    expAn    = lit ? ~(one << d) : 4'hF;
    nib      = shownD[4*d +: 4];
    leadZero = prevBlankLead && (d > 0) && ((shownD >> (4*d)) == 16'h0);
    expSeg   = (lit && !leadZero) ? segTab[nib] : 7'h7F;
    expDp    = lit ? ~shownP[d] : 1'b1;
    expFd    = ((t % FRAME) == FRAME - 1);
    check("an", {28'h0, an}, {28'h0, expAn});
    check("seg", {25'h0, seg}, {25'h0, expSeg});
    check("dp", {31'h0, dp}, {31'h0, expDp});
    check("frame_done", {31'h0, frame_done}, {31'h0, expFd});
  endtask

  initial begin
    logic resetNow, didReset;
    logic [15:0] mask;
    segTab[0] = 7'b1000000; segTab[1] = 7'b1111001; segTab[2] = 7'b0100100;
    segTab[3] = 7'b0110000; segTab[4] = 7'b0011001; segTab[5] = 7'b0010010;
    segTab[6] = 7'b0000010; segTab[7] = 7'b1111000; segTab[8] = 7'b0000000;
    segTab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) segTab[i] = 7'b0111111;
    prevBlankLead = 1'b0;
    prevBlink     = 1'b0;
    didReset      = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    for (int cyc = 0; cyc < TOTAL; cyc++) begin
      resetNow  = 1'b0;
      load      = 1'b0;
      digits_in = 16'h0;
      dp_in     = 4'h0;
      if (cyc < 160) begin
        // Directed opening: mid-frame load, leading zeros, multi-load and bypass.
        blank_lead = (cyc >= 64 && cyc < 128);
        blink      = 1'b0;
        case (cyc)
          40:  begin load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0100; end
          70:  begin load = 1'b1; digits_in = 16'h0050; end
          100: begin load = 1'b1; digits_in = 16'h1111; end
          110: begin load = 1'b1; digits_in = 16'h2222; end
          127: begin load = 1'b1; digits_in = 16'h3333; end
          default: ;
        endcase
      end else begin
        if (!didReset && cyc >= 1200 && (t % FRAME) == 20) begin
          resetNow = 1'b1;
          didReset = 1'b1;
        end else if ($urandom_range(15) == 0) begin
          case ($urandom_range(3))
            0:       mask = 16'hFFFF;
            1:       mask = 16'h00FF;
            2:       mask = 16'h000F;
            default: mask = 16'h0000;
          endcase
          load      = 1'b1;
          digits_in = 16'($urandom) & mask;
          dp_in     = 4'($urandom);
        end
        if ((cyc % 7) == 0) blank_lead = 1'($urandom);
        if ((cyc % 40) == 0) blink = ($urandom_range(3) != 0);
      end
      rst = resetNow;
      @(negedge clk);
      checkOutputs();
      @(posedge clk);
      if (resetNow) begin
        modelReset();
      end else begin
        if (load) begin
          latestD = digits_in;
          latestP = dp_in;
        end
        if ((t % FRAME) == FRAME - 1) begin
          shownD = latestD;
          shownP = latestP;
        end
        t++;
      end
      prevBlankLead = blank_lead;
      prevBlink     = blink;
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
